ibuf_banked_queue: RTL

Parametrised successor to the frontend instruction buffer. A banked circular queue between predecode and decode: it accepts up to IN_WIDTH instructions per cycle and presents up to OUT_WIDTH per cycle. It adds an explicit enqueue-ready handshake and consumer-controlled partial dequeue (deq_num), and supports independent in/out widths. A redirect flush empties it in one cycle.

---
 rtl/ibuf_banked_queue_pkg.sv | 28 ++
 rtl/ibuf_banked_queue_bank.sv | 25 ++
 rtl/ibuf_banked_queue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ibuf_banked_queue_pkg.sv
// Shared frontend definitions for the banked instruction buffer: default
// geometry, the stored entry layout and the bank-count derivation.
package ibuf_banked_queue_pkg;

  localparam int IBUF_IN_WIDTH  = 4;
  localparam int IBUF_OUT_WIDTH = 4;
  localparam int IBUF_DEPTH     = 16;
  localparam int IBUF_FSQ_IDX_W = 4;
  localparam int IBUF_INST_W    = 32;

  localparam int IBUF_OFF_W = $clog2(IBUF_IN_WIDTH);
  localparam int IBUF_PTR_W = $clog2(IBUF_DEPTH);
  localparam int IBUF_CNT_W = IBUF_PTR_W + 1;

  // One queued instruction together with its fetch-group bookkeeping.
  typedef struct packed {
    logic [IBUF_FSQ_IDX_W-1:0] fsq_idx;
    logic [IBUF_OFF_W-1:0]     offset;
    logic [IBUF_INST_W-1:0]    inst;
  } ibuf_entry_t;

  // Enough banks that neither a full input group nor a full output window
  // ever needs two accesses to the same bank in one cycle.
  function automatic int ibuf_num_banks(input int in_w, input int out_w);
    return (in_w > out_w) ? in_w : out_w;
  endfunction

endpackage

// File: rtl/ibuf_banked_queue_bank.sv
// Single bank of the instruction buffer: one synchronous write port and one
// combinational read port. Contents are intentionally not reset.
module ibuf_bank #(
  parameter  int WIDTH = 38,
  parameter  int ROWS  = 4,
  localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [ROWS];

  // Row write; no reset so this maps onto plain RAM/flop arrays.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ibuf_banked_queue.sv
// Banked circular instruction queue between predecode and decode.
// Accepts up to IN_WIDTH instructions per cycle when in_ready is high and
// presents up to OUT_WIDTH from the head; the consumer takes deq_num of them.
// A redirect empties the queue in one cycle.
// Optional build macro IBUF_PERF_EN adds saturating full/stall cycle counters.
module ibuf_banked_queue
  import ibuf_banked_queue_pkg::*;
#(
  parameter  int IN_WIDTH  = IBUF_IN_WIDTH,
  parameter  int OUT_WIDTH = IBUF_OUT_WIDTH,
  parameter  int DEPTH     = IBUF_DEPTH,
  parameter  int FSQ_IDX_W = IBUF_FSQ_IDX_W,
  localparam int IN_NUM_W  = $clog2(IN_WIDTH) + 1,
  localparam int OUT_NUM_W = $clog2(OUT_WIDTH) + 1,
  localparam int OFF_W     = $clog2(IN_WIDTH),
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                redirect,
  input  logic [IN_WIDTH-1:0]                 in_en,
  input  logic [IN_NUM_W-1:0]                 in_num,
  input  logic [FSQ_IDX_W-1:0]                in_fsq_idx,
  input  logic [IN_WIDTH-1:0][31:0]           in_inst,
  output logic                                in_ready,
  output logic [OUT_WIDTH-1:0]                out_en,
  output logic [OUT_WIDTH-1:0][31:0]          out_inst,
  output logic [OUT_WIDTH-1:0][FSQ_IDX_W-1:0] out_fsq_idx,
  output logic [OUT_WIDTH-1:0][OFF_W-1:0]     out_offset,
  input  logic [OUT_NUM_W-1:0]                deq_num,
  output logic [CNT_W-1:0]                    count,
  output logic                                full
`ifdef IBUF_PERF_EN
  ,
  output logic [31:0]                         perf_full_cycles,
  output logic [31:0]                         perf_stall_cycles
`endif
);

  localparam int NB     = ibuf_num_banks(IN_WIDTH, OUT_WIDTH);
  localparam int BANK_W = $clog2(NB);
  localparam int ROWS   = DEPTH / NB;
  localparam int ROW_W  = PTR_W - BANK_W;
  localparam int ENT_W  = $bits(ibuf_entry_t);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic                       enq_fire;
  logic [CNT_W-1:0]           avail;
  logic [CNT_W-1:0]           in_eff;
  logic [CNT_W-1:0]           deq_eff;

  logic [NB-1:0]              slot_en;
  ibuf_entry_t [NB-1:0]       slot_entry;

  logic [NB-1:0]              bank_we;
  logic [NB-1:0][ROW_W-1:0]   bank_waddr;
  logic [NB-1:0][ROW_W-1:0]   bank_raddr;
  ibuf_entry_t [NB-1:0]       bank_wdata;
  ibuf_entry_t [NB-1:0]       bank_rdata;

  // Handshake and occupancy arithmetic; in_ready looks only at registered count.
  always_comb begin
    in_ready = (count_q <= CNT_W'(DEPTH - IN_WIDTH));
    full     = (count_q == CNT_W'(DEPTH));
    enq_fire = in_en[0] && in_ready && !redirect;
    in_eff   = enq_fire ? CNT_W'(in_num) : '0;
    avail    = (count_q > CNT_W'(OUT_WIDTH)) ? CNT_W'(OUT_WIDTH) : count_q;
    deq_eff  = (CNT_W'(deq_num) > avail) ? avail : CNT_W'(deq_num);
  end

  // Pack each input slot into a stored entry, widened to one lane per bank.
  always_comb begin
    slot_en    = '0;
    slot_entry = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      slot_en[i]            = in_en[i];
      slot_entry[i].fsq_idx = in_fsq_idx;
      slot_entry[i].offset  = OFF_W'(i);
      slot_entry[i].inst    = in_inst[i];
    end
  end

  // Write steering: bank b receives input slot (b - tail) mod NB at row (tail+slot)/NB.
  always_comb begin
    logic [BANK_W-1:0] slot;
    logic [PTR_W-1:0]  ptr;
    slot       = '0;
    ptr        = '0;
    bank_we    = '0;
    bank_waddr = '0;
    bank_wdata = '0;
    for (int b = 0; b < NB; b++) begin
      slot          = BANK_W'(b) - tail_q[BANK_W-1:0];
      ptr           = tail_q + PTR_W'(slot);
      bank_we[b]    = enq_fire && slot_en[slot];
      bank_waddr[b] = ptr[PTR_W-1:BANK_W];
      bank_wdata[b] = slot_entry[slot];
    end
  end

  // Read steering: bank b serves output slot (b - head) mod NB.
  always_comb begin
    logic [BANK_W-1:0] slot;
    logic [PTR_W-1:0]  ptr;
    slot       = '0;
    ptr        = '0;
    bank_raddr = '0;
    for (int b = 0; b < NB; b++) begin
      slot          = BANK_W'(b) - head_q[BANK_W-1:0];
      ptr           = head_q + PTR_W'(slot);
      bank_raddr[b] = ptr[PTR_W-1:BANK_W];
    end
  end

  // Rotate bank read data back into head-relative output order.
  always_comb begin
    logic [BANK_W-1:0] bsel;
    bsel        = '0;
    out_en      = '0;
    out_inst    = '0;
    out_fsq_idx = '0;
    out_offset  = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      bsel           = head_q[BANK_W-1:0] + BANK_W'(k);
      out_en[k]      = (CNT_W'(k) < count_q);
      out_inst[k]    = bank_rdata[bsel].inst;
      out_fsq_idx[k] = bank_rdata[bsel].fsq_idx;
      out_offset[k]  = bank_rdata[bsel].offset;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    ibuf_bank #(
      .WIDTH (ENT_W),
      .ROWS  (ROWS)
    ) u_bank (
      .clk_i   (clk),
      .we_i    (bank_we[b]),
      .waddr_i (bank_waddr[b]),
      .wdata_i (bank_wdata[b]),
      .raddr_i (bank_raddr[b]),
      .rdata_o (bank_rdata[b])
    );
  end

  // Next pointer/count state; redirect overrides both enqueue and dequeue.
  always_comb begin
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_eff);
      tail_d  = tail_q + PTR_W'(in_eff);
      count_d = count_q + in_eff - deq_eff;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef IBUF_PERF_EN
  logic [31:0] perf_full_q;
  logic [31:0] perf_stall_q;

  // Saturating event counters; only reset clears them, redirect does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_full_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (in_en[0] && !in_ready && (perf_full_q != '1))
        perf_full_q <= perf_full_q + 32'd1;
      if ((count_q != '0) && (deq_num == '0) && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_full_cycles  = perf_full_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

`ifndef SYNTHESIS
  // The consumer may never take more than is presented; the datapath clamps anyway.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (CNT_W'(deq_num) <= avail)
        else $error("ibuf: deq_num %0d exceeds presented %0d", deq_num, avail);
    end
  end
`endif

endmodule
